// File: rtl/cory_rdma1d_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cory_rdma1d_pkg
//  Description : Shared types and helpers for the 1D read DMA (FSM encoding,
//                integer log2 used to derive bus geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package cory_rdma1d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Ceiling log2; exact for powers of two, which is all the bus width allows.
  function automatic int f_log2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cory_queue.sv
`default_nettype none
// ============================================================================
//  Module      : cory_queue
//  Description : Small valid/ready FIFO used as the read-data to stream
//                buffer. Full-registered occupancy; ready is simply "not full".
//  Revision    : 1.0 - initial release
// ============================================================================
module cory_queue #(
  parameter int N = 8,
  parameter int Q = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_v,
  input  logic [N-1:0] in_d,
  output logic         in_r,
  output logic         out_v,
  output logic [N-1:0] out_d,
  input  logic         out_r
);

  localparam int PW = (Q > 1) ? $clog2(Q) : 1;
  localparam int CW = $clog2(Q + 1);

  logic [N-1:0]  mem [Q];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(Q - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_r  = (count != CW'(Q));
  assign out_v = (count != '0);
  assign out_d = mem[rd_ptr];
  assign push  = in_v & in_r;
  assign pop   = out_v & out_r;

  // Payload storage; contents are don't-care until counted as occupied.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_d;
  end

  // Pointers and occupancy; reset drops anything queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= f_inc(wr_ptr);
      if (pop)  rd_ptr <= f_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cory_rdma1d.sv
`default_nettype none
// ============================================================================
//  Module      : cory_rdma1d
//  Description : Read-only 1D DMA. Splits a (base, byte width) command into
//                read bursts of up to 2^L beats, bounds outstanding bursts,
//                and re-emits the read data as a stream tagged with the
//                command's final beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module cory_rdma1d
  import cory_rdma1d_pkg::*;
#(
  parameter int A = 32,
  parameter int L = 4,
  parameter int D = 64,
  parameter int R = 11,
  parameter int Q = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_cmd_v,
  input  logic [R-1:0] i_cmd_width,
  input  logic [A-1:0] i_cmd_base,
  output logic         o_cmd_r,
  output logic         o_ar_v,
  output logic [A-1:0] o_ar_a,
  output logic [L-1:0] o_ar_l,
  input  logic         i_ar_r,
  input  logic         i_r_v,
  input  logic         i_r_l,
  input  logic [D-1:0] i_r_d,
  output logic         o_r_r,
  output logic         o_dout_v,
  output logic [D-1:0] o_dout_d,
  output logic         o_dout_l,
  input  logic         i_dout_r
);

  localparam int BUS_WIDTH = D / 8;
  localparam int BW        = f_log2(BUS_WIDTH);
  localparam int MAX_BYTE  = (2 ** L) * BUS_WIDTH;
  localparam int OW        = f_log2(Q + 1);
  localparam int CW        = R + 1;   // data byte counter may round past width

  state_t        state;
  state_t        state_nxt;
  logic [R-1:0]  cmd_width;
  logic [A-1:0]  addr;
  logic [R-1:0]  ar_cnt;
  logic [CW-1:0] dat_cnt;
  logic [OW-1:0] outstanding;

  logic [R-1:0]  rem;
  logic [R-1:0]  len_byte;
  logic [L:0]    beats;
  logic          ar_v;
  logic          ar_hs;
  logic          final_ar;
  logic          r_hs;
  logic          r_last_hs;
  logic          dout_hs;
  logic          cmd_hs;
  logic          beat_last;
  logic          q_in_r;
  logic          q_out_v;
  logic          q_out_l;

  // Burst sizing: remaining bytes clipped to one max burst, partial word rounds up.
  always_comb begin
    rem      = cmd_width - ar_cnt;
    len_byte = (32'(rem) > MAX_BYTE) ? R'(MAX_BYTE) : rem;
    beats    = (L+1)'(len_byte >> BW) + (L+1)'(|(len_byte & R'(BUS_WIDTH - 1)));
    final_ar = ({1'b0, ar_cnt} + {1'b0, len_byte}) >= {1'b0, cmd_width};
  end

  assign ar_v      = (state == ST_RUN) && (cmd_width != '0) && (outstanding < OW'(Q));
  assign ar_hs     = ar_v & i_ar_r;
  assign r_hs      = i_r_v & o_r_r;
  assign r_last_hs = r_hs & i_r_l;
  assign dout_hs   = q_out_v & i_dout_r;
  assign cmd_hs    = i_cmd_v & o_cmd_r;
  assign beat_last = (dat_cnt + CW'(BUS_WIDTH)) >= {1'b0, cmd_width};

  assign o_cmd_r  = (state == ST_IDLE);
  assign o_ar_v   = ar_v;
  assign o_ar_a   = ar_v ? addr : '0;
  assign o_ar_l   = ar_v ? L'(beats - (L+1)'(1)) : '0;
  assign o_r_r    = q_in_r && (state != ST_IDLE);
  assign o_dout_v = q_out_v;
  assign o_dout_l = q_out_v & q_out_l;

  cory_queue #(
    .N (D + 1),
    .Q (2)
  ) u_out_q (
    .clk     (clk),
    .reset_n (reset_n),
    .in_v    (r_hs),
    .in_d    ({beat_last, i_r_d}),
    .in_r    (q_in_r),
    .out_v   (q_out_v),
    .out_d   ({q_out_l, o_dout_d}),
    .out_r   (i_dout_r)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: idle -> issue bursts -> drain stream -> idle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_hs) state_nxt = ST_RUN;
      ST_RUN: begin
        if (cmd_width == '0)        state_nxt = ST_IDLE;
        else if (ar_hs && final_ar) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (dout_hs && o_dout_l) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, address/byte counters and outstanding-burst tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_width   <= '0;
      addr        <= '0;
      ar_cnt      <= '0;
      dat_cnt     <= '0;
      outstanding <= '0;
    end else if (cmd_hs) begin
      cmd_width   <= i_cmd_width;
      addr        <= i_cmd_base;
      ar_cnt      <= '0;
      dat_cnt     <= '0;
      outstanding <= '0;
    end else begin
      if (ar_hs) begin
        ar_cnt <= ar_cnt + len_byte;
        addr   <= addr + A'(len_byte);
      end
      if (r_hs) dat_cnt <= dat_cnt + CW'(BUS_WIDTH);
      case ({ar_hs, r_last_hs})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - OW'(1);
        default: ;
      endcase
    end
  end

`ifdef SIM
  int unsigned exp_beats[$];
  int unsigned beat_idx;

  // Bus monitor: R-last must land exactly on the beat count each AR asked for.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_beats.delete();
      beat_idx = 0;
    end else begin
      if ((D > 1024) || (BUS_WIDTH < 1) || ((1 << BW) != BUS_WIDTH)) begin
        $error("cory_rdma1d: unsupported data width D=%0d", D);
        $finish;
      end
      if (ar_hs) exp_beats.push_back(int'(o_ar_l) + 1);
      if (r_last_hs && (outstanding == '0))
        $error("cory_rdma1d: R-last with no outstanding burst");
      if (r_hs && (exp_beats.size() != 0)) begin
        beat_idx++;
        if (i_r_l != (beat_idx == exp_beats[0]))
          $error("cory_rdma1d: R-last at beat %0d, burst length %0d", beat_idx, exp_beats[0]);
        if (i_r_l) begin
          void'(exp_beats.pop_front());
          beat_idx = 0;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cory_rdma1d.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cory_rdma1d
//  Description : Self-checking bench for cory_rdma1d: randomized AXI-style
//                read slave and stream sink, command-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cory_rdma1d;

  localparam int A = 32;
  localparam int L = 4;
  localparam int D = 64;
  localparam int R = 11;
  localparam int Q = 2;
  localparam int BYTES_PER_BEAT = D / 8;                 // 8
  localparam int BURST_BYTES    = (2 ** L) * (D / 8);    // 128

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_cmd_v = 1'b0;
  logic [R-1:0] i_cmd_width = '0;
  logic [A-1:0] i_cmd_base = '0;
  logic         o_cmd_r;
  logic         o_ar_v;
  logic [A-1:0] o_ar_a;
  logic [L-1:0] o_ar_l;
  logic         i_ar_r = 1'b0;
  logic         i_r_v = 1'b0;
  logic         i_r_l = 1'b0;
  logic [D-1:0] i_r_d = '0;
  logic         o_r_r;
  logic         o_dout_v;
  logic [D-1:0] o_dout_d;
  logic         o_dout_l;
  logic         i_dout_r = 1'b0;

  cory_rdma1d #(.A(A), .L(L), .D(D), .R(R), .Q(Q)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_cmd_v     (i_cmd_v),
    .i_cmd_width (i_cmd_width),
    .i_cmd_base  (i_cmd_base),
    .o_cmd_r     (o_cmd_r),
    .o_ar_v      (o_ar_v),
    .o_ar_a      (o_ar_a),
    .o_ar_l      (o_ar_l),
    .i_ar_r      (i_ar_r),
    .i_r_v       (i_r_v),
    .i_r_l       (i_r_l),
    .i_r_d       (i_r_d),
    .o_r_r       (o_r_r),
    .o_dout_v    (o_dout_v),
    .o_dout_d    (o_dout_d),
    .o_dout_l    (o_dout_l),
    .i_dout_r    (i_dout_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Slave / sink behaviour knobs.
  int ar_pct = 100;
  int r_pct = 100;
  int dout_pct = 100;
  bit r_hold = 1'b0;
  bit dout_stall = 1'b0;

  // Slave state and observation logs.
  logic [A-1:0] pend_a[$];
  int           pend_n[$];
  int           r_idx = 0;
  bit           r_hs_s = 1'b0;
  logic [A-1:0] ar_a_log[$];
  logic [L-1:0] ar_l_log[$];
  int           ar_cyc_log[$];
  logic [D-1:0] dd_log[$];
  bit           dl_log[$];
  bit           last_seen = 1'b0;
  int           first_rlast_cyc = -1;
  int           r_acc_cnt = 0;

  // Memory contents as seen by the slave: unique per byte address.
  function automatic logic [D-1:0] word(input logic [A-1:0] a);
    return {a ^ 32'hC0DE_5A5A, a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Read slave and stream sink: drive after the falling edge, then record the
  // handshakes that the next rising edge will complete.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend_a.delete();
        pend_n.delete();
        r_idx  = 0;
        r_hs_s = 1'b0;
        i_ar_r = 1'b0;
        i_r_v  = 1'b0;
        i_r_l  = 1'b0;
        i_r_d  = '0;
        i_dout_r = 1'b0;
      end else begin
        bit want;
        i_ar_r = ($urandom_range(99) < ar_pct);
        want = (i_r_v && !r_hs_s) || (!r_hold && ($urandom_range(99) < r_pct));
        if (pend_a.size() > 0 && want) begin
          i_r_v = 1'b1;
          i_r_d = word(pend_a[0] + A'(BYTES_PER_BEAT * r_idx));
          i_r_l = (r_idx == pend_n[0] - 1);
        end else begin
          i_r_v = 1'b0;
          i_r_l = 1'b0;
        end
        i_dout_r = !dout_stall && ($urandom_range(99) < dout_pct);
        #2;
        if (reset_n) begin
          r_hs_s = i_r_v && o_r_r;
          if (o_ar_v && i_ar_r) begin
            pend_a.push_back(o_ar_a);
            pend_n.push_back(int'(o_ar_l) + 1);
            ar_a_log.push_back(o_ar_a);
            ar_l_log.push_back(o_ar_l);
            ar_cyc_log.push_back(cyc + 1);
          end
          if (r_hs_s && pend_n.size() > 0) begin
            r_acc_cnt++;
            if (i_r_l && first_rlast_cyc < 0) first_rlast_cyc = cyc + 1;
            if (r_idx == pend_n[0] - 1) begin
              void'(pend_a.pop_front());
              void'(pend_n.pop_front());
              r_idx = 0;
            end else begin
              r_idx++;
            end
          end
          if (o_dout_v && i_dout_r) begin
            dd_log.push_back(o_dout_d);
            dl_log.push_back(o_dout_l);
            if (o_dout_l) last_seen = 1'b1;
          end
        end
      end
    end
  end

  task automatic set_knobs(input int ap, input int rp, input int dp);
    ar_pct = ap;
    r_pct = rp;
    dout_pct = dp;
  endtask

  // Present one command; returns just after the accepting edge.
  task automatic issue_cmd(input logic [A-1:0] base, input int width);
    ar_a_log.delete();
    ar_l_log.delete();
    ar_cyc_log.delete();
    dd_log.delete();
    dl_log.delete();
    last_seen = 1'b0;
    first_rlast_cyc = -1;
    r_acc_cnt = 0;
    @(negedge clk);
    i_cmd_v = 1'b1;
    i_cmd_base = base;
    i_cmd_width = R'(width);
    @(posedge clk);
    #1;
    i_cmd_v = 1'b0;
    if (width != 0) begin
      #2;
      checks++;
      if (o_ar_v !== 1'b1) begin
        errors++;
        $display("FAIL ar_latency: o_ar_v=%b expected 1", o_ar_v);
      end
    end
  endtask

  task automatic wait_beats(input int n, input string name);
    int k;
    k = 0;
    while (dd_log.size() < n && k < 2000) begin
      @(posedge clk);
      #3;
      k++;
    end
    checks++;
    if (dd_log.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: beats=%0d expected >=%0d", name, dd_log.size(), n);
    end
  endtask

  // Wait for the final stream beat, then compare everything observed against
  // the burst split and data expected from (base, width).
  task automatic wait_done(input logic [A-1:0] base, input int width, input string name);
    int n;
    bit prev;
    logic [A-1:0] a;
    int rem, len, bts, k, nb;
    prev = last_seen;
    n = 0;
    while (!last_seen && n < 4000) begin
      @(posedge clk);
      #3;
      n++;
    end
    checks++;
    if (!last_seen) begin
      errors++;
      $display("FAIL %s_done: last beat not seen, got 0 expected 1", name);
    end else if (!prev) begin
      checks++;
      if (o_cmd_r !== 1'b1) begin
        errors++;
        $display("FAIL %s_cmd_r_after: o_cmd_r=%b expected 1", name, o_cmd_r);
      end
    end
    a = base;
    rem = width;
    k = 0;
    while (rem > 0) begin
      len = (rem > BURST_BYTES) ? BURST_BYTES : rem;
      bts = (len + BYTES_PER_BEAT - 1) / BYTES_PER_BEAT;
      if (k < ar_a_log.size()) begin
        checks++;
        if (ar_a_log[k] !== a || int'(ar_l_log[k]) != bts - 1) begin
          errors++;
          $display("FAIL %s_ar%0d: got a=%0h l=%0d expected a=%0h l=%0d",
                   name, k, ar_a_log[k], ar_l_log[k], a, bts - 1);
        end
      end
      a = a + A'(len);
      rem = rem - len;
      k++;
    end
    checks++;
    if (ar_a_log.size() != k) begin
      errors++;
      $display("FAIL %s_ar_count: got %0d expected %0d", name, ar_a_log.size(), k);
    end
    nb = (width + BYTES_PER_BEAT - 1) / BYTES_PER_BEAT;
    checks++;
    if (dd_log.size() != nb) begin
      errors++;
      $display("FAIL %s_beat_count: got %0d expected %0d", name, dd_log.size(), nb);
    end
    for (int i = 0; i < nb && i < dd_log.size(); i++) begin
      checks++;
      if (dd_log[i] !== word(base + A'(BYTES_PER_BEAT * i)) || dl_log[i] !== (i == nb - 1)) begin
        errors++;
        $display("FAIL %s_beat%0d: got d=%0h l=%b expected d=%0h l=%b", name, i,
                 dd_log[i], dl_log[i], word(base + A'(BYTES_PER_BEAT * i)), (i == nb - 1));
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({o_cmd_r, o_ar_v, o_r_r, o_dout_v, o_dout_l} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 10000", {o_cmd_r, o_ar_v, o_r_r, o_dout_v, o_dout_l});
    end
    checks++;
    if (o_ar_a !== '0 || o_ar_l !== '0) begin
      errors++;
      $display("FAIL reset_ar: got a=%0h l=%0h expected 0 0", o_ar_a, o_ar_l);
    end
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #3;
    checks++;
    if (o_cmd_r !== 1'b1 || o_ar_v !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got cmd_r=%b ar_v=%b expected 1 0", o_cmd_r, o_ar_v);
    end
  endtask

  task automatic test_single();
    set_knobs(100, 100, 100);
    issue_cmd(32'h100, 8);
    wait_done(32'h100, 8, "single");
  endtask

  task automatic test_multi_burst();
    set_knobs($urandom_range(100, 40), $urandom_range(100, 40), $urandom_range(100, 40));
    issue_cmd(32'h1000, 300);
    wait_done(32'h1000, 300, "multi");
  endtask

  task automatic test_outstanding();
    set_knobs(100, 100, 100);
    r_hold = 1'b1;
    issue_cmd(32'h2000, 1024);
    repeat (20) @(posedge clk);
    #3;
    checks++;
    if (ar_a_log.size() != Q || o_ar_v !== 1'b0) begin
      errors++;
      $display("FAIL outst_limit: got ars=%0d ar_v=%b expected %0d 0", ar_a_log.size(), o_ar_v, Q);
    end
    r_hold = 1'b0;
    wait_done(32'h2000, 1024, "outst");
    checks++;
    if (ar_cyc_log.size() < 3 || ar_cyc_log[2] != first_rlast_cyc + 1) begin
      errors++;
      $display("FAIL outst_third_ar: got cycle %0d expected %0d",
               (ar_cyc_log.size() < 3) ? -1 : ar_cyc_log[2], first_rlast_cyc + 1);
    end
  endtask

  task automatic test_back_pressure();
    int r0;
    set_knobs(100, 100, 100);
    issue_cmd(32'h3000, 256);
    wait_beats(5, "bp");
    dout_stall = 1'b1;
    r0 = r_acc_cnt;
    repeat (20) @(posedge clk);
    #3;
    checks++;
    if ((r_acc_cnt - r0) > 2 || o_r_r !== 1'b0 || o_dout_v !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: got r_acc=%0d r_r=%b dout_v=%b expected <=2 0 1",
               r_acc_cnt - r0, o_r_r, o_dout_v);
    end
    dout_stall = 1'b0;
    wait_done(32'h3000, 256, "bp");
  endtask

  task automatic test_zero_width();
    set_knobs(100, 100, 100);
    issue_cmd(32'h800, 0);
    #2;
    checks++;
    if (o_cmd_r !== 1'b0 || o_ar_v !== 1'b0) begin
      errors++;
      $display("FAIL zero_run: got cmd_r=%b ar_v=%b expected 0 0", o_cmd_r, o_ar_v);
    end
    @(posedge clk);
    #3;
    checks++;
    if (o_cmd_r !== 1'b1) begin
      errors++;
      $display("FAIL zero_idle: o_cmd_r=%b expected 1", o_cmd_r);
    end
    repeat (5) @(posedge clk);
    #3;
    checks++;
    if (ar_a_log.size() != 0 || dd_log.size() != 0) begin
      errors++;
      $display("FAIL zero_quiet: got ars=%0d beats=%0d expected 0 0", ar_a_log.size(), dd_log.size());
    end
  endtask

  task automatic test_reset_mid();
    set_knobs(100, 100, 100);
    issue_cmd(32'h4000, 1024);
    wait_beats(3, "rst_mid");
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({o_cmd_r, o_ar_v, o_r_r, o_dout_v, o_dout_l} !== 5'b10000 || o_ar_a !== '0 || o_ar_l !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b a=%0h l=%0h expected 10000 0 0",
               {o_cmd_r, o_ar_v, o_r_r, o_dout_v, o_dout_l}, o_ar_a, o_ar_l);
    end
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    issue_cmd(32'h5000, 16);
    wait_done(32'h5000, 16, "after_rst");
  endtask

  task automatic test_random();
    logic [A-1:0] base;
    int width;
    for (int i = 0; i < 6; i++) begin
      set_knobs($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30));
      width = $urandom_range(700, 1);
      base = A'($urandom_range(32'hFFFF, 0)) << 3;
      issue_cmd(base, width);
      wait_done(base, width, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_burst();
    test_outstanding();
    test_back_pressure();
    test_zero_width();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
